// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single line-wide off-chip memory port between the instruction
// cache and the data cache. One requester owns the port at a time. The memory
// request is registered and held frozen until the memory acknowledges it. The
// acknowledge and the read line are then routed back to the owner.
//
// Parameters
//   ADDR_W  byte address width on all ports
//   LINE_W  cache line / memory data width
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   i_enable_i, i_addr_i      I-cache line read request (held until i_ack_o)
//   i_data_o, i_ack_o         read line / one-cycle completion to the I-cache
//   d_enable_i, d_write_i     D-cache request (held until d_ack_o), 1 = write
//   d_addr_i, d_data_i        D-cache line address / write-back line
//   d_data_o, d_ack_o         read line / one-cycle completion to the D-cache
//   mem_data_i, mem_ack_i     memory read line, valid with the completion pulse
//   mem_data_o, mem_addr_o    registered memory write line / address
//   mem_enable_o, mem_write_o registered memory request / write strobe
//   grant_o                   current owner: 00 none, 01 I-cache, 10 D-cache
//
// Build option
//   ARB_DCACHE_PRIORITY_EN  when defined, the D-cache wins every tie (fixed
//                           priority). When undefined, ties alternate
//                           round-robin against the last served requester.
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_enable_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [LINE_W-1:0] i_data_o,
    output logic              i_ack_o,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic [LINE_W-1:0] d_data_o,
    output logic              d_ack_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    state_e            state_q, state_d;
    // last_d_q is 1 when the most recent completed transaction belonged to the
    // D-cache; it is reset to 1 so that the first tie goes to the I-cache.
    logic              last_d_q, last_d_d;
    logic              cool_i_q, cool_i_d;
    logic              cool_d_q, cool_d_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;
    logic [1:0]        grant_q, grant_d;

    logic              elig_i, elig_d;
    logic              pick_i, pick_d;

    // A requester served on the previous ack edge is masked for one IDLE
    // cycle, so an enable that drops one cycle late does not re-win the port.
    assign elig_i = i_enable_i & ~cool_i_q;
    assign elig_d = d_enable_i & ~cool_d_q;

`ifdef ARB_DCACHE_PRIORITY_EN
    // Fixed priority: the D-cache takes every tie. The cooldown mask still
    // hands the waiting I-cache the slot right after each D transaction.
    assign pick_d = elig_d;
    assign pick_i = elig_i & ~elig_d;
`else
    // Round-robin: on a tie the requester that was not served last wins.
    assign pick_i = elig_i & (~elig_d | last_d_q);
    assign pick_d = elig_d & (~elig_i | ~last_d_q);
`endif

    // Next-state logic. In IDLE a winner is chosen and its request is captured
    // into the memory-side registers. In BUSY everything stays frozen until the
    // memory acknowledges, then the port is released and the winner is cooled.
    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        cool_i_d     = cool_i_q;
        cool_d_d     = cool_d_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        grant_d      = grant_q;

        case (state_q)
            IDLE: begin
                // Masks only ever survive a single IDLE cycle.
                cool_i_d = 1'b0;
                cool_d_d = 1'b0;
                if (pick_i) begin
                    state_d      = BUSY_I;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = i_addr_i;
                    mem_data_d   = '0;
                    grant_d      = GRANT_I;
                end else if (pick_d) begin
                    state_d      = BUSY_D;
                    mem_enable_d = 1'b1;
                    mem_write_d  = d_write_i;
                    mem_addr_d   = d_addr_i;
                    mem_data_d   = d_data_i;
                    grant_d      = GRANT_D;
                end
            end

            BUSY_I: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    last_d_d     = 1'b0;
                    cool_i_d     = 1'b1;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = '0;
                    mem_data_d   = '0;
                    grant_d      = GRANT_NONE;
                end
            end

            BUSY_D: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    last_d_d     = 1'b1;
                    cool_d_d     = 1'b1;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = '0;
                    mem_data_d   = '0;
                    grant_d      = GRANT_NONE;
                end
            end

            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
                mem_addr_d   = '0;
                mem_data_d   = '0;
                grant_d      = GRANT_NONE;
            end
        endcase
    end

    // State and memory-side registers. Reset abandons any in-flight
    // transaction: returning to IDLE also removes the ack path to its owner.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b1;
            cool_i_q     <= 1'b0;
            cool_d_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            grant_q      <= GRANT_NONE;
        end else begin
            state_q      <= state_d;
            last_d_q     <= last_d_d;
            cool_i_q     <= cool_i_d;
            cool_d_q     <= cool_d_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            grant_q      <= grant_d;
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign grant_o      = grant_q;

    // The memory completion goes straight back to the owner only; an ack
    // arriving while IDLE reaches nobody. Read lines are zero outside the ack.
    assign i_ack_o  = (state_q == BUSY_I) & mem_ack_i;
    assign d_ack_o  = (state_q == BUSY_D) & mem_ack_i;
    assign i_data_o = i_ack_o ? mem_data_i : '0;
    assign d_data_o = d_ack_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for mem_port_arbiter. A transaction-level model tracks
// who owns the port and what request was captured for it. A compare process
// checks every DUT output against that model once per cycle. Directed
// scenarios pin the model with hand-computed values, and a randomized phase
// then drives all inputs freely.
// ============================================================================
module tb_mem_port_arbiter;

    logic         clk;
    logic         rstN;
    logic         iEnable;
    logic [31:0]  iAddr;
    logic [255:0] iData;
    logic         iAck;
    logic         dEnable;
    logic         dWrite;
    logic [31:0]  dAddr;
    logic [255:0] dDataIn;
    logic [255:0] dData;
    logic         dAck;
    logic [255:0] memDataIn;
    logic         memAck;
    logic [255:0] memData;
    logic [31:0]  memAddr;
    logic         memEnable;
    logic         memWrite;
    logic [1:0]   grant;

    int checks;
    int failures;
    bit cmpEn;

    // Model state: owner 0 = nobody, 1 = I-cache, 2 = D-cache.
    int           mOwner;
    int           mLast;
    int           mCool;
    logic [31:0]  mAddr;
    logic         mWrite;
    logic [255:0] mData;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk_i        (clk),
        .rst_i        (rstN),
        .i_enable_i   (iEnable),
        .i_addr_i     (iAddr),
        .i_data_o     (iData),
        .i_ack_o      (iAck),
        .d_enable_i   (dEnable),
        .d_write_i    (dWrite),
        .d_addr_i     (dAddr),
        .d_data_i     (dDataIn),
        .d_data_o     (dData),
        .d_ack_o      (dAck),
        .mem_data_i   (memDataIn),
        .mem_ack_i    (memAck),
        .mem_data_o   (memData),
        .mem_addr_o   (memAddr),
        .mem_enable_o (memEnable),
        .mem_write_o  (memWrite),
        .grant_o      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drives every input at the falling edge so the DUT samples stable values.
    task automatic applyStimulus(input logic ie, input logic [31:0] ia,
                                 input logic de, input logic dw, input logic [31:0] da,
                                 input logic [255:0] dd, input logic ma, input logic [255:0] md);
        @(negedge clk);
        iEnable   = ie;
        iAddr     = ia;
        dEnable   = de;
        dWrite    = dw;
        dAddr     = da;
        dDataIn   = dd;
        memAck    = ma;
        memDataIn = md;
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN      = 1'b0;
        iEnable   = 1'b0;
        iAddr     = '0;
        dEnable   = 1'b0;
        dWrite    = 1'b0;
        dAddr     = '0;
        dDataIn   = '0;
        memAck    = 1'b0;
        memDataIn = '0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic afterEdge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Transaction-level reference: an owner, the captured request and a
    // one-cycle "just served" marker. Evaluated on the same edges as the DUT.
    always @(posedge clk or negedge rstN) begin
        bit wantI;
        bit wantD;
        int winner;
        if (!rstN) begin
            mOwner = 0;
            mLast  = 2;
            mCool  = 0;
            mAddr  = '0;
            mWrite = 1'b0;
            mData  = '0;
        end else if (mOwner != 0) begin
            if (memAck) begin
                mLast  = mOwner;
                mCool  = mOwner;
                mOwner = 0;
                mAddr  = '0;
                mWrite = 1'b0;
                mData  = '0;
            end
        end else begin
            wantI  = iEnable && (mCool != 1);
            wantD  = dEnable && (mCool != 2);
            mCool  = 0;
            winner = 0;
            if (wantI && wantD) begin
`ifdef ARB_DCACHE_PRIORITY_EN
                winner = 2;
`else
                winner = (mLast == 1) ? 2 : 1;
`endif
            end else if (wantI) begin
                winner = 1;
            end else if (wantD) begin
                winner = 2;
            end
            if (winner == 1) begin
                mOwner = 1;
                mAddr  = iAddr;
                mWrite = 1'b0;
                mData  = '0;
            end else if (winner == 2) begin
                mOwner = 2;
                mAddr  = dAddr;
                mWrite = dWrite;
                mData  = dDataIn;
            end
        end
    end

    // Per-cycle comparison of every output against the model, shortly after
    // the inputs for the cycle have been applied.
    always @(negedge clk) begin
        logic expIAck;
        logic expDAck;
        #1;
        if (cmpEn) begin
            expIAck = (mOwner == 1) && memAck;
            expDAck = (mOwner == 2) && memAck;
            checkOutput("mem_enable", memEnable, (mOwner != 0));
            checkOutput("mem_write", memWrite, mWrite);
            checkOutput("mem_addr", memAddr, mAddr);
            checkOutput("mem_data", memData, mData);
            checkOutput("grant", grant, mOwner[1:0]);
            checkOutput("i_ack", iAck, expIAck);
            checkOutput("d_ack", dAck, expDAck);
            checkOutput("i_data", iData, expIAck ? memDataIn : 256'd0);
            checkOutput("d_data", dData, expDAck ? memDataIn : 256'd0);
        end
    end

    initial begin
        logic [255:0] lineA5;
        logic [255:0] line1234;
        logic [1:0]   firstGrant;
        logic [1:0]   secondGrant;

        lineA5   = {32{8'hA5}};
        line1234 = {16{16'h1234}};
        checks   = 0;
        failures = 0;
        cmpEn    = 1'b0;
        rstN     = 1'b0;

        doReset();
        cmpEn = 1'b1;
        checkOutput("reset_grant", grant, 2'b00);
        checkOutput("reset_mem_enable", memEnable, 1'b0);

        // Single I-cache read with a 10-cycle memory latency.
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
        afterEdge();
        checkOutput("iread_enable", memEnable, 1'b1);
        checkOutput("iread_addr", memAddr, 32'h40);
        checkOutput("iread_write", memWrite, 1'b0);
        checkOutput("iread_grant", grant, 2'b01);
        repeat (9) applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, lineA5);
        #2;
        checkOutput("iread_ack", iAck, 1'b1);
        checkOutput("iread_data", iData, lineA5);
        checkOutput("iread_dack", dAck, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        afterEdge();
        checkOutput("iread_grant_end", grant, 2'b00);

        // D-cache write-back: memory request stays frozen while inputs move.
        doReset();
        applyStimulus(0, 0, 1, 1, 32'h100, line1234, 0, 0);
        afterEdge();
        checkOutput("dwb_write", memWrite, 1'b1);
        checkOutput("dwb_data", memData, line1234);
        applyStimulus(0, 0, 1, 0, 32'h999, 256'h5, 0, 0);
        afterEdge();
        checkOutput("dwb_data_held", memData, line1234);
        checkOutput("dwb_addr_held", memAddr, 32'h100);
        checkOutput("dwb_write_held", memWrite, 1'b1);
        applyStimulus(0, 0, 1, 1, 32'h100, line1234, 1, 0);
        #2;
        checkOutput("dwb_ack", dAck, 1'b1);
        checkOutput("dwb_iack", iAck, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous requests straight out of reset.
`ifdef ARB_DCACHE_PRIORITY_EN
        firstGrant  = 2'b10;
        secondGrant = 2'b01;
`else
        firstGrant  = 2'b01;
        secondGrant = 2'b10;
`endif
        doReset();
        applyStimulus(1, 32'h200, 1, 0, 32'h300, 0, 0, 0);
        afterEdge();
        checkOutput("tie_first", grant, firstGrant);
        applyStimulus(1, 32'h200, 1, 0, 32'h300, 0, 1, randLine());
        afterEdge();
        checkOutput("tie_gap", memEnable, 1'b0);
        applyStimulus(1, 32'h200, 1, 0, 32'h300, 0, 0, 0);
        afterEdge();
        checkOutput("tie_second", grant, secondGrant);
        applyStimulus(1, 32'h200, 1, 0, 32'h300, 0, 1, randLine());
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // D keeps its enable one cycle past its ack: no regrant that cycle.
        doReset();
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 0, 0);
        afterEdge();
        checkOutput("late_grant", grant, 2'b10);
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 1, randLine());
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 0, 0);
        afterEdge();
        checkOutput("late_masked", memEnable, 1'b0);
        applyStimulus(0, 0, 1, 0, 32'h540, 0, 0, 0);
        afterEdge();
        checkOutput("late_regrant", grant, 2'b10);
        checkOutput("late_regrant_addr", memAddr, 32'h540);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset lands three cycles into a D transaction.
        doReset();
        applyStimulus(0, 0, 1, 1, 32'h400, line1234, 0, 0);
        afterEdge();
        checkOutput("rst_busy_grant", grant, 2'b10);
        repeat (3) @(negedge clk);
        #3;
        rstN    = 1'b0;
        dEnable = 1'b0;
        iEnable = 1'b1;
        iAddr   = 32'h600;
        #1;
        checkOutput("rst_async_enable", memEnable, 1'b0);
        checkOutput("rst_async_grant", grant, 2'b00);
        checkOutput("rst_async_write", memWrite, 1'b0);
        checkOutput("rst_async_data", memData, 256'd0);
        @(negedge clk);
        memAck    = 1'b1;
        memDataIn = lineA5;
        #2;
        checkOutput("rst_no_dack", dAck, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        #2;
        checkOutput("rst_rel_dack", dAck, 1'b0);
        afterEdge();
        checkOutput("rst_pending_i", grant, 2'b01);
        checkOutput("rst_pending_addr", memAddr, 32'h600);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Memory ack while idle is ignored.
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, lineA5);
        #2;
        checkOutput("idle_iack", iAck, 1'b0);
        checkOutput("idle_dack", dAck, 1'b0);
        afterEdge();
        checkOutput("idle_grant", grant, 2'b00);
        checkOutput("idle_enable", memEnable, 1'b0);

        // Randomized phase: every input free-running, with the odd reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 2) != 0, $urandom,
                              $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom,
                              randLine(), $urandom_range(0, 3) == 0, randLine());
            end
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 256-bit off-chip memory port between the instruction cache and the data cache. Each cache issues one line-sized transaction (read, or write for the data cache only) and holds it until acknowledged. The arbiter grants one requester at a time and holds the memory request stable until mem_ack_i. It returns the acknowledge and read line to the granted requester. It sits between the two cache controllers and the memory model, in place of the direct Data_Cache-to-memory wiring.

Parameters:
ADDR_W, 32, byte address width on all ports
LINE_W, 256, cache line / memory data width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
i_enable_i  in  1  I-cache line read request, held until i_ack_o
i_addr_i  in  ADDR_W  I-cache line address
i_data_o  out  LINE_W  read line to I-cache
i_ack_o  out  1  one-cycle completion pulse to I-cache
d_enable_i  in  1  D-cache request, held until d_ack_o
d_write_i  in  1  1 = write-back, 0 = line fill
d_addr_i  in  ADDR_W  D-cache line address
d_data_i  in  LINE_W  write-back line
d_data_o  out  LINE_W  read line to D-cache
d_ack_o  out  1  one-cycle completion pulse to D-cache
mem_data_i  in  LINE_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion pulse
mem_data_o  out  LINE_W  memory write data
mem_addr_o  out  ADDR_W  memory address
mem_enable_o  out  1  memory request, held until mem_ack_i
mem_write_o  out  1  memory write strobe
grant_o  out  2  current owner: 00 none, 01 I-cache, 10 D-cache

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE.
  - mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, grant_o all 0.
  - last_grant set to D, so the first tie goes to I.
  - Cooldown masks cleared.
  - Any in-flight transaction is abandoned; no ack is issued for it.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Eligible requester = enable high and not masked by cooldown.
  - On the clock edge where one or both are eligible, pick a winner.
  - At that same edge: load mem_addr_o, mem_write_o and mem_data_o from the winner; set mem_enable_o=1; set grant_o; enter BUSY_x.
  - Request-to-mem_enable_o latency is exactly 1 cycle.
- Grant for the I-cache: mem_write_o=0, mem_data_o=0.
- Tie (both eligible): grant the requester that is not last_grant (round-robin).
- BUSY_x:
  - All mem_* outputs and grant_o stay frozen regardless of requester input changes.
  - x_ack_o = mem_ack_i (combinational, gated by state == BUSY_x).
  - x_data_o = mem_data_i (combinational passthrough, valid only while x_ack_o is high).
  - On the edge with mem_ack_i=1: go to IDLE, clear mem_enable_o, mem_write_o, mem_addr_o, mem_data_o and grant_o, set last_grant=x, set cooldown mask for x.
- Cooldown:
  - The just-served requester is ineligible for the first IDLE cycle after its ack.
  - This tolerates a requester that drops its enable one cycle late.
  - The mask clears after that one IDLE cycle.
  - The other requester may be granted in that cycle.
- Read-data outputs: i_data_o and d_data_o are 0 whenever their ack is low.
- mem_ack_i in IDLE is ignored: no ack output, no state change.
- A requester deasserting enable while it is the owner does not abort the transaction. The ack still pulses, and the requester ignores it.
- A requester that is not the owner waits; its ack stays 0.
- Maximum wait for either requester is one full transaction of the other plus the 1-cycle grant latency.
- Back-to-back transactions: minimum gap between consecutive mem_enable_o assertions is 1 IDLE cycle.

Optional Feature:
ARB_DCACHE_PRIORITY_EN
- Defined: on a tie the D-cache always wins (fixed priority); last_grant is not used for selection. Cooldown still applies, so the I-cache is guaranteed the slot right after each D transaction it was waiting on.
- Undefined: round-robin tie-break as specified above.

Test Plan:
- Single I read: i_enable_i=1, i_addr_i=0x0000_0040, memory acks after 10 cycles with data 0xA5..A5.
  - mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40 one cycle after request.
  - i_ack_o pulses 1 cycle with i_data_o=0xA5..A5.
  - d_ack_o stays 0; grant_o returns to 00.
- D write-back: d_write_i=1, d_addr_i=0x100, d_data_i=0x1234..
  - mem_write_o=1, mem_data_o=0x1234.. held constant until ack.
  - d_ack_o pulses once.
- Simultaneous requests out of reset:
  - I granted first (grant_o=01).
  - After ack, D granted in the next IDLE cycle (grant_o=10).
  - With ARB_DCACHE_PRIORITY_EN defined, D is granted first.
- D holds d_enable_i one cycle past d_ack_o, I idle:
  - No second D grant; mem_enable_o stays 0 for that cycle.
  - A new D request in the following cycle is granted.
- Reset asserted 3 cycles into a BUSY_D transaction:
  - All outputs become 0 immediately, without waiting for a clock edge.
  - A later mem_ack_i produces no d_ack_o.
  - After reset release, a pending i_enable_i is granted.
- mem_ack_i pulsed while IDLE with no requests: no ack outputs, grant_o stays 00.
